// File: rtl/user_code_loader_if.sv
// user_code_loader_if: byte-stream load handshake plus instruction fetch
// read port for the user-code bank.
//   start      : one-cycle pulse, begins/restarts a load (master -> slave)
//   byte_in    : stream byte (master -> slave)
//   byte_valid : byte_in valid (master -> slave)
//   byte_ready : loader accepts a byte this cycle (slave -> master)
//   rd_addr    : fetch address (master -> slave)
//   rd_data    : instruction word at rd_addr, combinational (slave -> master)
interface user_code_loader_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;

  modport master (
    output start, byte_in, byte_valid, rd_addr,
    input  byte_ready, rd_data
  );

  modport slave (
    input  start, byte_in, byte_valid, rd_addr,
    output byte_ready, rd_data
  );
endinterface

// File: rtl/user_code_loader.sv
// user_code_loader: writable user-code instruction bank. Assembles 16-bit
// words from a high-byte-first byte stream, writes word k to address k,
// and verifies the load with a trailing XOR checksum byte.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset (clears bank to zero)
//   bus          : stream handshake and asynchronous read port (slave side)
//   loading      : load in progress
//   done         : load finished with matching checksum (sticky)
//   error        : load finished with bad checksum (sticky)
//   words_loaded : words written during the current load
module user_code_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  user_code_loader_if.slave bus,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {IDLE, HI, LO, CHK} state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [WORDS];
  logic [ADDR_W-1:0] wptr;
  logic [7:0]        hi_reg;
  logic [7:0]        chk;
  logic              xfer;
  logic              last_word;

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign last_word = (wptr == ADDR_W'(WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.byte_ready = 1'b0;
    loading        = 1'b0;
    case (state)
      IDLE: ;
      HI: begin
        bus.byte_ready = 1'b1;
        loading        = 1'b1;
        if (xfer) state_nxt = LO;
      end
      LO: begin
        bus.byte_ready = 1'b1;
        loading        = 1'b1;
        if (xfer) state_nxt = last_word ? CHK : HI;
      end
      CHK: begin
        bus.byte_ready = 1'b1;
        loading        = 1'b1;
        if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // start overrides any byte transfer in the same cycle
    if (bus.start) state_nxt = HI;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem          <= '{default: '0};
      wptr         <= '0;
      hi_reg       <= '0;
      chk          <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else if (bus.start) begin
      wptr         <= '0;
      chk          <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else if (xfer) begin
      case (state)
        HI: begin
          hi_reg <= bus.byte_in;
          chk    <= chk ^ bus.byte_in;
        end
        LO: begin
          mem[wptr]    <= {hi_reg, bus.byte_in};
          chk          <= chk ^ bus.byte_in;
          wptr         <= wptr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        CHK: begin
          if (bus.byte_in == chk) done  <= 1'b1;
          else                    error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_data = mem[bus.rd_addr];

endmodule

// File: doc/user_code_loader.md
Name: user_code_loader

Overview:
- Writable replacement for the hardwired user-code instruction bank: receives a program as a byte stream (e.g. from a UART receiver), assembles 16-bit i281 instruction words and stores them in a 16-entry bank.
- The CPU's instruction fetch reads the bank through an asynchronous read port.
- The load ends with an XOR checksum byte; the result is reported on done/error.

Parameters:
- WORDS, 16, number of instruction words in the bank.
- ADDR_W, 4, address width; WORDS = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a load.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader accepts byte this cycle.
- rd_addr  input  ADDR_W  fetch address.
- rd_data  output  16  instruction word at rd_addr (combinational).
- loading  output  1  load in progress.
- done  output  1  load finished with correct checksum; sticky.
- error  output  1  load finished with bad checksum; sticky.
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - all WORDS entries cleared to 16'h0000 (NOP-equivalent zero fill);
  - state = IDLE; byte_ready = 0, loading = 0, done = 0, error = 0, words_loaded = 0;
  - checksum accumulator = 8'h00.
- Handshake:
  - A byte transfers on a rising edge where byte_valid & byte_ready.
  - byte_ready = 1 only in states HI, LO and CHK. It depends on state only, not on byte_valid.
  - Bytes presented while byte_ready = 0 are ignored, not buffered.
- States:
  - IDLE: start → HI. On the same edge: wptr = 0, words_loaded = 0, chk = 0, done = 0, error = 0.
  - HI: on transfer, hi_reg ← byte_in, chk ^= byte_in → LO.
  - LO: on transfer:
    - mem[wptr] ← {hi_reg, byte_in}, chk ^= byte_in;
    - words_loaded increments, wptr increments;
    - if wptr was WORDS-1 → CHK, else → HI.
  - CHK: on transfer:
    - if byte_in == chk → done = 1, else → error = 1;
    - → IDLE.
- Byte and word order:
  - high byte first (opcode/register fields), then low byte (immediate);
  - word k goes to address k, k = 0..WORDS-1;
  - no wrap-around: exactly WORDS words per load, then one checksum byte.
- loading = 1 in HI, LO and CHK.
- Memory writes: each word is written on its LO transfer edge, not held until checksum. After a checksum error the bank holds the new (unverified) contents; the CPU must be held off using error.
- start while loading: restarts the load. Back to HI with wptr, words_loaded and chk cleared, and any pending hi_reg byte discarded. Previously written words stay until overwritten. start has priority over a simultaneous byte transfer; that byte is dropped.
- start while done or error is set: clears both flags, begins a new load.
- Read port:
  - rd_data = mem[rd_addr], combinational, zero latency;
  - a write and a read of the same address in one cycle returns the old word until the edge, the new word after it.
- Checksum: XOR of all 2*WORDS data bytes, 8 bits.
- Reset mid-load: everything returns to the reset values above, including memory zero fill.

Test Plan:
- Reset, no load: read rd_addr 0..15 → all 16'h0000; byte_ready = 0, done = 0, error = 0.
- Pulse start, then send 80 00 84 01 11 02 followed by 26 zero bytes (words 3..15 = 0), then checksum 8'h16:
  - rd_data at addresses 0/1/2 = 16'h8000 / 16'h8401 / 16'h1102;
  - words_loaded = 16 before the checksum byte;
  - done = 1, error = 0, loading = 0.
- Same program with checksum 8'h17: error = 1, done = 0; the words are still written.
- Send 3 words, pulse start together with a valid byte, then send a full load:
  - the byte sent with start is ignored;
  - words_loaded restarts at 0;
  - the final bank holds only the second load; done = 1.
- Hold byte_valid low for several cycles between the HI and LO bytes: no write occurs until the LO transfer; words_loaded does not change while stalled.
- Assert reset_n = 0 after 5 words: immediately all outputs are at reset values and reads return 0; bytes sent afterwards without start are ignored.
